// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter.
// State encoding and master identifiers.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1,
    ARB_DRAIN
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic arb_state_e own_state(input logic m);
    return m ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle.
// Master drives request fields; slave drives response fields.
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        stall;
  logic [31:0] dat_o;

  modport master (
    output adr, dat, sel, we, cyc, stb,
    input  ack, err, stall, dat_o
  );

  modport slave (
    input  adr, dat, sel, we, cyc, stb,
    output ack, err, stall, dat_o
  );
endinterface

// File: rtl/wb_outst_cnt.sv
// Saturating up/down count of accepted-but-unacked strobes.
// Simultaneous inc and dec leave the count unchanged.
module wb_outst_cnt #(
  parameter int unsigned MAX = 2,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         up, dn;

  assign full_o  = (cnt_q == W'(MAX));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    up    = inc_i & ~full_o;
    dn    = dec_i & ~empty_o;
    cnt_d = cnt_q;
    if (up && !dn) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dn && !up) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arb2_rr.sv
// Two-master Wishbone B4 pipelined arbiter, round-robin,
// bus locked per cycle, responses routed by outstanding count.
module wb_arb2_rr
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter bit          M0_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       own0, own1;
  logic       cur_cyc, cur_stb, fwd_stb;
  logic       full, empty;
  logic       cnt_inc, cnt_dec;

  assign own0 = (state_q == ARB_OWN0);
  assign own1 = (state_q == ARB_OWN1);

  assign cur_cyc = own1 ? m1.cyc : (own0 & m0.cyc);
  assign cur_stb = own1 ? m1.stb : (own0 & m0.stb);
  // A strobe arriving with cyc low is illegal and is dropped here.
  assign fwd_stb = cur_cyc & cur_stb & ~full;

  assign s.cyc = cur_cyc;
  assign s.stb = fwd_stb;
  assign s.we  = (own0 & m0.we) | (own1 & m1.we);
  assign s.adr = own1 ? m1.adr : m0.adr;
  assign s.dat = own1 ? m1.dat : m0.dat;
  assign s.sel = own1 ? m1.sel : m0.sel;

  assign m0.stall = ~own0 | s.stall | full;
  assign m0.ack   = own0 & s.ack;
  assign m0.err   = own0 & s.err;
  assign m0.dat_o = s.dat_o;

  assign m1.stall = ~own1 | s.stall | full;
  assign m1.ack   = own1 & s.ack;
  assign m1.err   = own1 & s.err;
  assign m1.dat_o = s.dat_o;

  assign cnt_inc = fwd_stb & ~s.stall;
  assign cnt_dec = (s.ack | s.err) & (state_q != ARB_IDLE);

  wb_outst_cnt #(
    .MAX(MAX_OUTST)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (cnt_inc),
    .dec_i  (cnt_dec),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = own_state(~last_gnt_q);
        end else if (m0.cyc) begin
          state_d = ARB_OWN0;
        end else if (m1.cyc) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0.cyc) begin
          last_gnt_d = ARB_M0;
          state_d    = empty ? ARB_IDLE : ARB_DRAIN;
        end
      end
      ARB_OWN1: begin
        if (!m1.cyc) begin
          last_gnt_d = ARB_M1;
          state_d    = empty ? ARB_IDLE : ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (empty) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= M0_FIRST ? ARB_M1 : ARB_M0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed bench for wb_arb2_rr with a byte-lane SRAM model
// of programmable ack latency, plus a MAX_OUTST=1 instance.
module tb_wb_arb2_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   lat = 1;

  always #5 clk = ~clk;

  wb_if m0_if ();
  wb_if m1_if ();
  wb_if s_if ();
  wb_if n0_if ();
  wb_if n1_if ();
  wb_if t_if ();

  wb_arb2_rr #(.MAX_OUTST(2), .M0_FIRST(1'b1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if)
  );

  wb_arb2_rr #(.MAX_OUTST(1), .M0_FIRST(1'b1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .m0   (n0_if),
    .m1   (n1_if),
    .s    (t_if)
  );

  // SRAM model: never stalls, response after lat cycles
  logic [31:0] mem [256];
  logic        pv [1:4];
  logic        pe [1:4];
  logic [31:0] pd [1:4];
  logic        a_hit, a_bad;

  assign a_hit = s_if.cyc & s_if.stb;
  assign a_bad = (s_if.adr[31:16] != 16'h0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      for (int k = 1; k <= 4; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= 32'h0;
      end
    end else begin
      for (int k = 4; k > 1; k--) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pd[k] <= pd[k-1];
      end
      pv[1] <= a_hit;
      pe[1] <= a_bad;
      pd[1] <= (a_bad || s_if.we) ? 32'h0 : mem[s_if.adr[9:2]];
      if (a_hit && s_if.we && !a_bad) begin
        for (int b = 0; b < 4; b++) begin
          if (s_if.sel[b]) mem[s_if.adr[9:2]][8*b +: 8] <= s_if.dat[8*b +: 8];
        end
      end
    end
  end

  assign s_if.stall = 1'b0;
  assign s_if.ack   = pv[lat] & ~pe[lat];
  assign s_if.err   = pv[lat] & pe[lat];
  assign s_if.dat_o = pd[lat];

  // Second slave: fixed 1-cycle ack, no data
  logic t_ack;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_ack <= 1'b0;
    else        t_ack <= t_if.cyc & t_if.stb;
  end
  assign t_if.ack   = t_ack;
  assign t_if.err   = 1'b0;
  assign t_if.stall = 1'b0;
  assign t_if.dat_o = 32'h0;

  // Outstanding count must never exceed MAX nor wrap below zero
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (u_dut.u_cnt.cnt_q <= 2'd2) else begin
        fails++;
        $error("FAIL outst_range obs=%0d exp=<=2", u_dut.u_cnt.cnt_q);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic stall_of(input logic m);
    return m ? m1_if.stall : m0_if.stall;
  endfunction

  function automatic logic ack_of(input logic m);
    return m ? m1_if.ack : m0_if.ack;
  endfunction

  function automatic logic err_of(input logic m);
    return m ? m1_if.err : m0_if.err;
  endfunction

  function automatic logic [31:0] dat_of(input logic m);
    return m ? m1_if.dat_o : m0_if.dat_o;
  endfunction

  task automatic drv(input logic m, input logic cyc, input logic stb,
                     input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    if (m) begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
      m1_if.adr = adr; m1_if.dat = dat; m1_if.sel = sel;
    end else begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
      m0_if.adr = adr; m0_if.dat = dat; m0_if.sel = sel;
    end
  endtask

  // Single read from IDLE: grant stall, strobe, response, drop
  task automatic rd(input logic m, input logic [31:0] adr,
                    input logic [31:0] exp, input logic exp_err,
                    input string tag);
    logic om;
    logic ea;
    om = ~m;
    ea = ~exp_err;
    tick();
    drv(m, 1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF);
    mid();
    chk({tag, ".gnt_stall"}, stall_of(m), 1);
    chk({tag, ".gnt_sstb"}, s_if.stb, 0);
    tick();
    mid();
    chk({tag, ".stall"}, stall_of(m), 0);
    chk({tag, ".sstb"}, s_if.stb, 1);
    chk({tag, ".sadr"}, s_if.adr, adr);
    tick();
    if (m) m1_if.stb = 1'b0; else m0_if.stb = 1'b0;
    mid();
    chk({tag, ".ack"}, ack_of(m), ea);
    chk({tag, ".err"}, err_of(m), exp_err);
    chk({tag, ".dat"}, dat_of(m), exp);
    chk({tag, ".oth_ack"}, ack_of(om), 0);
    tick();
    if (m) m1_if.cyc = 1'b0; else m0_if.cyc = 1'b0;
  endtask

  logic [31:0] wd [4];
  logic [31:0] wa [4];

  initial begin
    wd[0] = 32'h1234_5678; wd[1] = 32'h9ABC_DEF0;
    wd[2] = 32'h0F1E_2D3C; wd[3] = 32'hCAFE_BABE;
    wa[0] = 32'h20; wa[1] = 32'h24; wa[2] = 32'h28; wa[3] = 32'h2C;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n0_if.cyc = 0; n0_if.stb = 0; n0_if.we = 0;
    n0_if.adr = 0; n0_if.dat = 0; n0_if.sel = 4'hF;
    n1_if.cyc = 0; n1_if.stb = 0; n1_if.we = 0;
    n1_if.adr = 0; n1_if.dat = 0; n1_if.sel = 4'h0;

    // reset values
    mid();
    chk("rst.m0_stall", m0_if.stall, 1);
    chk("rst.m1_stall", m1_if.stall, 1);
    chk("rst.m0_ack", m0_if.ack, 0);
    chk("rst.s_cyc", s_if.cyc, 0);
    chk("rst.s_stb", s_if.stb, 0);
    chk("rst.s_we", s_if.we, 0);
    tick();
    rst_n = 1'b1;

    // 1: single m0 read
    rd(1'b0, 32'h0000_0010, 32'hA500_0004, 1'b0, "t1");

    // 2: tie after reset goes to m0, bubble, then m1
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    mid();
    chk("t2.idle_scyc", s_if.cyc, 0);
    chk("t2.idle_m0stall", m0_if.stall, 1);
    tick(); mid();
    chk("t2.own0_m0stall", m0_if.stall, 0);
    chk("t2.own0_m1stall", m1_if.stall, 1);
    chk("t2.own0_scyc", s_if.cyc, 1);
    tick();
    m0_if.cyc = 1'b0;
    mid();
    chk("t2.drop_scyc", s_if.cyc, 0);
    tick(); mid();
    chk("t2.bubble_m1stall", m1_if.stall, 1);
    chk("t2.bubble_scyc", s_if.cyc, 0);
    tick(); mid();
    chk("t2.own1_m1stall", m1_if.stall, 0);
    chk("t2.own1_m0stall", m0_if.stall, 1);
    chk("t2.own1_scyc", s_if.cyc, 1);
    tick();
    m1_if.cyc = 1'b0;
    tick();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick(); mid();
    chk("t2.tie2_m0stall", m0_if.stall, 0);
    chk("t2.tie2_m1stall", m1_if.stall, 1);
    tick();
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;

    // 3: four back-to-back m1 writes, lanes 0-1 only
    tick();
    drv(1'b1, 1'b1, 1'b1, 1'b1, wa[0], wd[0], 4'b0011);
    mid();
    chk("t3.gnt_stall", m1_if.stall, 1);
    tick(); mid();
    chk("t3.w0_stall", m1_if.stall, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      m1_if.adr = wa[k]; m1_if.dat = wd[k];
      mid();
      chk($sformatf("t3.w%0d_stall", k), m1_if.stall, 0);
      chk($sformatf("t3.w%0d_ack", k), m1_if.ack, 1);
      chk($sformatf("t3.w%0d_outst", k), u_dut.u_cnt.cnt_q, 1);
    end
    tick();
    m1_if.stb = 1'b0;
    mid();
    chk("t3.last_ack", m1_if.ack, 1);
    tick();
    m1_if.cyc = 1'b0; m1_if.we = 1'b0;
    mid();
    chk("t3.done_ack", m1_if.ack, 0);
    chk("t3.done_outst", u_dut.u_cnt.cnt_q, 0);
    rd(1'b1, wa[0], 32'hA500_5678, 1'b0, "t3.rb0");
    rd(1'b1, wa[3], 32'hA500_BABE, 1'b0, "t3.rb3");
    rd(1'b1, 32'h0001_0000, 32'h0, 1'b1, "t3.err");

    // 4: MAX_OUTST=1 stalls the second strobe for one cycle
    tick();
    n0_if.cyc = 1'b1; n0_if.stb = 1'b1; n0_if.adr = 32'h40;
    mid();
    chk("t4.gnt_stall", n0_if.stall, 1);
    tick(); mid();
    chk("t4.s1_stall", n0_if.stall, 0);
    chk("t4.s1_tstb", t_if.stb, 1);
    tick();
    n0_if.adr = 32'h44;
    mid();
    chk("t4.s2_stall", n0_if.stall, 1);
    chk("t4.s2_outst", u_dut1.u_cnt.cnt_q, 1);
    chk("t4.s2_tstb", t_if.stb, 0);
    chk("t4.s2_ack", n0_if.ack, 1);
    tick(); mid();
    chk("t4.s2b_stall", n0_if.stall, 0);
    chk("t4.s2b_tstb", t_if.stb, 1);
    chk("t4.s2b_outst", u_dut1.u_cnt.cnt_q, 0);
    tick();
    n0_if.stb = 1'b0;
    mid();
    chk("t4.end_ack", n0_if.ack, 1);
    tick();
    n0_if.cyc = 1'b0;

    // 5: m0 aborts with one strobe in flight -> DRAIN
    lat = 3;
    tick();
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    m1_if.cyc = 1'b1;
    mid();
    chk("t5.gnt_stall", m0_if.stall, 1);
    tick(); mid();
    chk("t5.m0_stall", m0_if.stall, 0);
    chk("t5.sstb", s_if.stb, 1);
    tick();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    mid();
    chk("t5.abort_outst", u_dut.u_cnt.cnt_q, 1);
    tick(); mid();
    chk("t5.drain_scyc", s_if.cyc, 0);
    chk("t5.drain_m1stall", m1_if.stall, 1);
    tick(); mid();
    chk("t5.late_sack", s_if.ack, 1);
    chk("t5.late_m0ack", m0_if.ack, 0);
    chk("t5.late_m1ack", m1_if.ack, 0);
    chk("t5.late_m1stall", m1_if.stall, 1);
    tick(); mid();
    chk("t5.empty_outst", u_dut.u_cnt.cnt_q, 0);
    chk("t5.empty_m1stall", m1_if.stall, 1);
    tick(); mid();
    chk("t5.idle_m1stall", m1_if.stall, 1);
    tick(); mid();
    chk("t5.own1_m1stall", m1_if.stall, 0);
    chk("t5.own1_scyc", s_if.cyc, 1);
    tick();
    m1_if.cyc = 1'b0;

    // 6: reset while OWN1 with one strobe outstanding
    tick();
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    mid();
    chk("t6.gnt_stall", m1_if.stall, 1);
    tick(); mid();
    chk("t6.stall", m1_if.stall, 0);
    tick();
    m1_if.stb = 1'b0;
    mid();
    chk("t6.pre_outst", u_dut.u_cnt.cnt_q, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6.rst_m1stall", m1_if.stall, 1);
    chk("t6.rst_m0stall", m0_if.stall, 1);
    chk("t6.rst_m1ack", m1_if.ack, 0);
    chk("t6.rst_scyc", s_if.cyc, 0);
    chk("t6.rst_sstb", s_if.stb, 0);
    chk("t6.rst_swe", s_if.we, 0);
    chk("t6.rst_outst", u_dut.u_cnt.cnt_q, 0);
    m1_if.cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); mid();
    chk("t6.post_scyc", s_if.cyc, 0);
    chk("t6.post_outst", u_dut.u_cnt.cnt_q, 0);
    tick(); mid();
    chk("t6.post_sack", s_if.ack, 0);
    chk("t6.post_m1ack", m1_if.ack, 0);
    lat = 1;
    tick();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick(); mid();
    chk("t6.tie_m0stall", m0_if.stall, 0);
    chk("t6.tie_m1stall", m1_if.stall, 1);
    tick();
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

endmodule
